// File: rtl/inst_mem_loader.sv
// Instruction memory loader: streams 32-bit words into a byte-wide,
// big-endian instruction memory while holding the CPU in reset.
module inst_mem_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       in_word,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] TOP  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [7:0]        wd_q, wd_d;
    logic [7:0]        cur_byte;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= BASE;
            byte_idx_q <= 2'd0;
            word_q     <= 32'd0;
            last_q     <= 1'b0;
            count_q    <= '0;
            error_q    <= 1'b0;
            wa_q       <= '0;
            wd_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            last_q     <= last_d;
            count_q    <= count_d;
            error_q    <= error_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

    // MSB goes to the lowest address so fetch reassembles the word as-is
    always_comb begin
        cur_byte = word_q[31:24];
        unique case (byte_idx_q)
            2'd0: cur_byte = word_q[31:24];
            2'd1: cur_byte = word_q[23:16];
            2'd2: cur_byte = word_q[15:8];
            2'd3: cur_byte = word_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        last_d     = last_q;
        count_d    = count_q;
        error_d    = error_q;
        wa_d       = wa_q;
        wd_d       = wd_q;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE, S_ERR: begin
                cpu_hold = (state_q == S_ERR);
                if (start) begin
                    state_d    = S_WAIT;
                    addr_d     = BASE;
                    byte_idx_d = 2'd0;
                    count_d    = '0;
                    error_d    = 1'b0;
                end
            end
            S_WAIT: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (in_valid) begin
                    word_d     = in_word;
                    last_d     = in_last;
                    count_d    = count_q + 1'b1;
                    byte_idx_d = 2'd0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                cpu_hold   = 1'b1;
                wr_en      = 1'b1;
                wa_d       = addr_q;
                wd_d       = cur_byte;
                addr_d     = addr_q + 1'b1;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    // A final word ending on the top byte is a clean finish
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (addr_q == TOP) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_addr    = wr_en ? addr_q : wa_q;
    assign wr_data    = wr_en ? cur_byte : wd_q;
    assign error      = error_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: two small-memory instances (base 0 and base 8)
// sharing one stimulus path, with a write scoreboard and a byte image.
module tb_inst_mem_loader;

    localparam int AW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        logic        last;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] in_word = 32'd0;

    logic          rdy_a, we_a, hold_a, done_a, err_a;
    logic          rdy_b, we_b, hold_b, done_b, err_b;
    logic [AW-1:0] wa_a, wc_a, wa_b, wc_b;
    logic [7:0]    wd_a, wd_b;

    logic          in_ready, wr_en, cpu_hold, done, error;
    logic [AW-1:0] wr_addr, word_count;
    logic [7:0]    wr_data;

    int checks = 0;
    int errors = 0;
    wr_t sb[$];
    wr_t mon_e;
    logic [AW-1:0] exp_addr = '0;
    logic [7:0] mem [0:15];

    always #5 clock = ~clock;

    inst_mem_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut_a (
        .clock(clock), .reset(reset), .start(start & ~sel),
        .in_word(in_word), .in_valid(in_valid & ~sel), .in_last(in_last),
        .in_ready(rdy_a), .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a),
        .cpu_hold(hold_a), .done(done_a), .error(err_a), .word_count(wc_a)
    );

    inst_mem_loader #(.ADDR_W(AW), .BASE_ADDR(8)) dut_b (
        .clock(clock), .reset(reset), .start(start & sel),
        .in_word(in_word), .in_valid(in_valid & sel), .in_last(in_last),
        .in_ready(rdy_b), .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b),
        .cpu_hold(hold_b), .done(done_b), .error(err_b), .word_count(wc_b)
    );

    assign in_ready   = sel ? rdy_b  : rdy_a;
    assign wr_en      = sel ? we_b   : we_a;
    assign wr_addr    = sel ? wa_b   : wa_a;
    assign wr_data    = sel ? wd_b   : wd_a;
    assign cpu_hold   = sel ? hold_b : hold_a;
    assign done       = sel ? done_b : done_a;
    assign error      = sel ? err_b  : err_a;
    assign word_count = sel ? wc_b   : wc_a;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic push_bytes(input logic [31:0] e);
        wr_t w;
        for (int i = 0; i < 4; i++) begin
            w.addr = exp_addr;
            w.data = e[31-8*i -: 8];
            sb.push_back(w);
            exp_addr = exp_addr + 1'b1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic l,
                             input logic [31:0] e);
        bit ok;
        ok = 1'b0;
        in_word  = w;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                push_bytes(e);
            end
        end
        chk("accept", 32'(ok), 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            chk("done_pulse", 32'(done), 32'(k == 5));
            chk("hold_vs_done", 32'(cpu_hold), 32'(k != 5));
        end
        @(negedge clock);
        chk("done_once", 32'(done), 32'd0);
        chk("hold_idle", 32'(cpu_hold), 32'd0);
        @(posedge clock); #1;
    endtask

    task automatic do_start();
        start    = 1'b1;
        exp_addr = sel ? AW'(8) : AW'(0);
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    always @(negedge clock) begin
        if (wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                         wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(wr_data), 32'(mon_e.data));
            end
            mem[wr_addr] = wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [4];
        logic [63:0] img;
        int          nacc;
        bit          acc;

        tbl[0] = '{32'h00100113, 1'b0, 8'h00, 8'h10, 8'h01, 8'h13};
        tbl[1] = '{32'h00200193, 1'b1, 8'h00, 8'h20, 8'h01, 8'h93};
        tbl[2] = '{32'hDEADBEEF, 1'b0, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tbl[3] = '{32'h80000001, 1'b1, 8'h80, 8'h00, 8'h00, 8'h01};
        img = 64'h0010011300200193;

        // reset state
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // two-word programs from the vector table
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                do_start();
                @(negedge clock);
                chk("start_hold", 32'(cpu_hold), 32'd1);
                chk("start_ready", 32'(in_ready), 32'd1);
                chk("start_count", 32'(word_count), 32'd0);
                @(posedge clock); #1;
            end
            send_word(tbl[i].word, tbl[i].last,
                      {tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3});
            if (tbl[i].last) begin
                wait_done();
                chk("tbl_count", 32'(word_count), 32'd2);
                chk("tbl_error", 32'(error), 32'd0);
            end
            if (i == 1) begin
                for (int j = 0; j < 8; j++)
                    chk("t1_image", 32'(mem[j]), 32'(img[63-8*j -: 8]));
            end
        end

        // in_valid held high: one accept per 5 cycles
        do_start();
        in_word  = 32'h11223344;
        in_last  = 1'b0;
        in_valid = 1'b1;
        nacc = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            chk("t2_ready", 32'(in_ready), 32'(c % 5 == 0));
            acc = in_ready;
            if (acc) begin
                push_bytes(in_word);
                nacc++;
            end
            @(posedge clock); #1;
            if (acc) in_word = in_word + 32'h01010101;
        end
        in_valid = 1'b0;
        chk("t2_accepts", 32'(nacc), 32'd3);
        chk("t2_count", 32'(word_count), 32'd3);

        // last word on the final four bytes completes cleanly
        send_word(32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
        wait_done();
        chk("t4_error", 32'(error), 32'd0);
        chk("t4_count", 32'(word_count), 32'd4);

        // overflow without last
        do_start();
        for (int i = 0; i < 4; i++)
            send_word(32'hA0B0C0D0 + i, 1'b0, 32'hA0B0C0D0 + i);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            chk("t3_wr_en", 32'(wr_en), 32'(k != 5));
        end
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_ready", 32'(in_ready), 32'd0);
        chk("t3_hold", 32'(cpu_hold), 32'd1);
        @(posedge clock); #1;
        in_word  = 32'h55555555;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            chk("t3_no_accept", 32'(in_ready), 32'd0);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("t3_count", 32'(word_count), 32'd4);
        chk("t3_sticky", 32'(error), 32'd1);

        // reset during the second write cycle
        do_start();
        @(negedge clock);
        chk("t5_err_clr", 32'(error), 32'd0);
        chk("t5_count0", 32'(word_count), 32'd0);
        @(posedge clock); #1;
        send_word(32'h12345678, 1'b0, 32'h12345678);
        @(negedge clock);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("t5_wr_en", 32'(wr_en), 32'd0);
        chk("t5_hold", 32'(cpu_hold), 32'd0);
        chk("t5_ready", 32'(in_ready), 32'd0);
        chk("t5_count", 32'(word_count), 32'd0);
        chk("t5_pending", 32'(sb.size()), 32'd3);
        sb.delete();
        @(posedge clock); #1 reset = 1'b0;
        do_start();
        send_word(32'h9ABCDEF0, 1'b1, 32'h9ABCDEF0);
        chk("t5_reload_count", 32'(word_count), 32'd1);
        wait_done();
        chk("t5_mem0", 32'(mem[0]), 32'h9A);

        // base 8 instance: start ignored mid-load, honoured in ERR
        sel = 1'b1;
        do_start();
        @(negedge clock);
        chk("t6_count0", 32'(word_count), 32'd0);
        @(posedge clock); #1;
        send_word(32'h01020304, 1'b0, 32'h01020304);
        @(negedge clock);
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        repeat (2) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        chk("t6_wait_count", 32'(word_count), 32'd1);
        chk("t6_wait_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        send_word(32'h05060708, 1'b0, 32'h05060708);
        for (int k = 1; k <= 5; k++) @(negedge clock);
        chk("t6_error", 32'(error), 32'd1);
        chk("t6_hold", 32'(cpu_hold), 32'd1);
        @(posedge clock); #1;
        do_start();
        @(negedge clock);
        chk("t6_err_clr", 32'(error), 32'd0);
        chk("t6_restart_count", 32'(word_count), 32'd0);
        chk("t6_restart_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        send_word(32'hF00DBABE, 1'b1, 32'hF00DBABE);
        wait_done();
        chk("t6_mem8", 32'(mem[8]), 32'hF0);
        chk("t6_mem11", 32'(mem[11]), 32'hBE);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
